serial_subtractor: RTL

- Bit-serial fixed-point subtractor: computes Diff = A - B - Bin, LSB first, one bit per clock.
- Uses a single full-subtractor cell and a registered borrow.
- It is the inverse-operation counterpart to the ALU's ripple adder path.
- Sits beside the adder in the fixed-point ALU and serves area-constrained subtract/compare operations.
- A Start/Busy/Done handshake is driven by the ALU controller.

---
 rtl/serial_subtractor.sv | 195 +++++++++++++++++++
 1 files changed

// File: rtl/serial_subtractor.sv
// serial_subtractor: bit-serial Diff = A - B - Bin, LSB first, one bit per clock,
// built from a single full-subtractor cell and a registered borrow.
//
// Ports:
//   Clk    rising-edge clock
//   Rst_n  synchronous active-low reset (clears state and all outputs)
//   Start  request pulse, sampled only while idle
//   A, B   minuend / subtrahend, captured on an accepted Start
//   Bin    borrow-in, captured on an accepted Start
//   Busy   high from the accepting edge until the edge after the Done cycle
//   Done   one-cycle pulse; Diff/Bout/Ovf valid from this cycle
//   Diff   registered difference, held until the next result or reset
//   Bout   unsigned borrow out of the MSB (1 = A < B + Bin)
//   Ovf    signed (two's complement) overflow
//
// Optional feature macro: SERIAL_SUB_SAT_EN
//   When defined, an overflowing result is clamped to the signed limit chosen
//   by the original sign of A. Bout/Ovf always report the unsaturated status.
//
// Timing (Start accepted at edge k): bits are processed at edges k+1..k+WIDTH,
// the result is published at edge k+WIDTH+1 (Done=1 for one cycle), and Busy
// falls at edge k+WIDTH+2 unless a new Start is accepted at that same edge.

module serial_subtractor #(
  parameter int unsigned WIDTH = 8
) (
  input  logic             Clk,
  input  logic             Rst_n,
  input  logic             Start,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  input  logic             Bin,
  output logic             Busy,
  output logic             Done,
  output logic [WIDTH-1:0] Diff,
  output logic             Bout,
  output logic             Ovf
);

  localparam int unsigned CNT_W = (WIDTH > 2) ? $clog2(WIDTH) : 1;
  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(WIDTH - 1);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } state_t;

  state_t             state_q,   state_d;
  logic [WIDTH-1:0]   a_sh_q,    a_sh_d;
  logic [WIDTH-1:0]   b_sh_q,    b_sh_d;
  logic [WIDTH-1:0]   res_sh_q,  res_sh_d;
  logic               br_q,      br_d;
  logic               br_msb_q,  br_msb_d;
  logic [CNT_W-1:0]   cnt_q,     cnt_d;
  logic               busy_q,    busy_d;
  logic               done_q,    done_d;
  logic [WIDTH-1:0]   diff_q,    diff_d;
  logic               bout_q,    bout_d;
  logic               ovf_q,     ovf_d;
`ifdef SERIAL_SUB_SAT_EN
  logic               a_msb_q,   a_msb_d;
  logic [WIDTH-1:0]   sat_val_c;
`endif

  // Full-subtractor cell on the current LSBs of the operand shift registers
  logic bit_a_c, bit_b_c, bit_d_c, br_next_c;

  always_comb begin
    bit_a_c   = a_sh_q[0];
    bit_b_c   = b_sh_q[0];
    bit_d_c   = bit_a_c ^ bit_b_c ^ br_q;
    br_next_c = (~bit_a_c & bit_b_c) | (~(bit_a_c ^ bit_b_c) & br_q);
  end

`ifdef SERIAL_SUB_SAT_EN
  // Signed limit in the direction of the original minuend sign
  always_comb begin
    sat_val_c = a_msb_q ? {1'b1, {(WIDTH-1){1'b0}}} : {1'b0, {(WIDTH-1){1'b1}}};
  end
`endif

  // Next-state and output decode
  always_comb begin
    state_d  = state_q;
    a_sh_d   = a_sh_q;
    b_sh_d   = b_sh_q;
    res_sh_d = res_sh_q;
    br_d     = br_q;
    br_msb_d = br_msb_q;
    cnt_d    = cnt_q;
    busy_d   = 1'b0;
    done_d   = 1'b0;
    diff_d   = diff_q;
    bout_d   = bout_q;
    ovf_d    = ovf_q;
`ifdef SERIAL_SUB_SAT_EN
    a_msb_d  = a_msb_q;
`endif

    case (state_q)
      ST_IDLE: begin
        if (Start) begin
          a_sh_d   = A;
          b_sh_d   = B;
          res_sh_d = '0;
          br_d     = Bin;
          cnt_d    = '0;
          busy_d   = 1'b1;
          state_d  = ST_RUN;
`ifdef SERIAL_SUB_SAT_EN
          a_msb_d  = A[WIDTH-1];
`endif
        end
      end

      ST_RUN: begin
        busy_d   = 1'b1;
        a_sh_d   = {1'b0, a_sh_q[WIDTH-1:1]};
        b_sh_d   = {1'b0, b_sh_q[WIDTH-1:1]};
        res_sh_d = {bit_d_c, res_sh_q[WIDTH-1:1]};
        br_d     = br_next_c;
        if (cnt_q == LAST_CNT) begin
          // Borrow entering the MSB is kept for the signed overflow test
          br_msb_d = br_q;
          cnt_d    = '0;
          state_d  = ST_DONE;
        end else begin
          cnt_d    = cnt_q + CNT_W'(1);
        end
      end

      ST_DONE: begin
        busy_d  = 1'b1;
        done_d  = 1'b1;
        bout_d  = br_q;
        ovf_d   = br_msb_q ^ br_q;
`ifdef SERIAL_SUB_SAT_EN
        diff_d  = (br_msb_q ^ br_q) ? sat_val_c : res_sh_q;
`else
        diff_d  = res_sh_q;
`endif
        state_d = ST_IDLE;
      end

      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // State and output registers with synchronous active-low reset
  always_ff @(posedge Clk) begin
    if (!Rst_n) begin
      state_q  <= ST_IDLE;
      a_sh_q   <= '0;
      b_sh_q   <= '0;
      res_sh_q <= '0;
      br_q     <= 1'b0;
      br_msb_q <= 1'b0;
      cnt_q    <= '0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
      diff_q   <= '0;
      bout_q   <= 1'b0;
      ovf_q    <= 1'b0;
`ifdef SERIAL_SUB_SAT_EN
      a_msb_q  <= 1'b0;
`endif
    end else begin
      state_q  <= state_d;
      a_sh_q   <= a_sh_d;
      b_sh_q   <= b_sh_d;
      res_sh_q <= res_sh_d;
      br_q     <= br_d;
      br_msb_q <= br_msb_d;
      cnt_q    <= cnt_d;
      busy_q   <= busy_d;
      done_q   <= done_d;
      diff_q   <= diff_d;
      bout_q   <= bout_d;
      ovf_q    <= ovf_d;
`ifdef SERIAL_SUB_SAT_EN
      a_msb_q  <= a_msb_d;
`endif
    end
  end

  assign Busy = busy_q;
  assign Done = done_q;
  assign Diff = diff_q;
  assign Bout = bout_q;
  assign Ovf  = ovf_q;

endmodule
